block_accumulator: RTL
======================

Name: block_accumulator

Overview:
- Parametrised successor of the combinational block adder.
- Owns the A_M x B_N result matrix in internal registers and merges one J x K product block into it at (start_row, start_col).
- Merging is either accumulate (result += block) or overwrite.
- Processes LANES elements per cycle under a start/busy/done handshake; out-of-matrix elements are clipped. Sits between the block multiplier and the result readout logic.

Parameters:
DATA_W, 32, element width (IEEE-754 single for fadd)
J, 2, block rows
K, 2, block columns
A_M, 4, result matrix rows
B_N, 4, result matrix columns
LANES, 1, elements merged per cycle (1..J*K)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  request merge; accepted only when busy=0
mode  in  1  0 = accumulate, 1 = overwrite; sampled with start
start_row  in  10  block origin row; sampled with start
start_col  in  10  block origin column; sampled with start
blk_in  in  J*K*DATA_W  flattened block, element i*K+j at bits [(i*K+j)*DATA_W +: DATA_W]; sampled with start
clear  in  1  zero whole matrix; accepted only when busy=0
busy  out  1  high in RUN/CLEAR/DONE
done  out  1  one-cycle pulse when merge or clear completes
rd_addr  in  $clog2(A_M*B_N)  read address, row-major (r*B_N+c)
rd_data  out  DATA_W  registered read data, 1-cycle latency

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all matrix words 0; busy=0, done=0, rd_data=0; element counter 0.
  - Reset mid-RUN abandons the merge; no partial state survives.
- States: IDLE, RUN, CLEAR, DONE.
- IDLE:
  - clear=1 -> CLEAR. Clear has priority; start in the same cycle is dropped.
  - Else start=1 -> latch mode, start_row, start_col, blk_in; counter e=0; -> RUN.
- RUN, each cycle, for each lane l=0..LANES-1, with idx=e+l:
  - Skip if idx >= J*K.
  - i=idx/K, j=idx%K; r=start_row+i, c=start_col+j computed at 11 bits, no wrap.
  - If r<A_M and c<B_N: mem[r*B_N+c] <= mode ? blk[idx] : fadd(mem[r*B_N+c], blk[idx]). Otherwise the element is clipped: no write.
  - e <= e+LANES. When e+LANES >= J*K -> DONE.
  - Addresses within one block are distinct, so lanes never collide.
- CLEAR: all words <= 0 in one cycle -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start sampled at edge t; RUN occupies ceil(J*K/LANES) cycles; done high in the cycle after the last RUN cycle; busy deasserts with return to IDLE. With J=K=2, LANES=1: RUN cycles t+1..t+4, done at t+5. A new start is accepted the cycle after done.
- start or clear while busy=1: ignored; no queueing.
- Origin fully outside the matrix: RUN still runs the full count with zero writes; done still pulses.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in any state.
  - Read-before-write: a word written in cycle n reads new data from the read issued in cycle n+1.
  - rd_addr >= A_M*B_N returns 0.
- fadd is purely combinational; no extra pipeline stages are added.

Optional Feature:
BLK_ACC_CLIP_ERR_EN:
- Defined: adds output clip_err (1 bit).
  - Set in DONE if any element of that merge was clipped.
  - Held until the next accepted start or clear, both of which clear it.
  - Reset value 0.
- Undefined: port absent; clipping is silent.

Decomposition:
- Shared package block_pkg:
  - DATA_W, J, K, A_M, B_N defaults.
  - State enum (IDLE/RUN/CLEAR/DONE).
  - FP constants FP_ZERO, FP_ONE=32'h3F800000.
  - Address-width function.
- One sub-module, block_acc_lane, instantiated LANES times:
  - Index-to-(r,c) mapping, bounds check, wraps one fadd, mode mux.
  - Outputs write-enable, write address, write data.

Test Plan (defaults, LANES=1):
1. Reset: hold rst_n low 3 cycles, release; read addr 0..15 -> all 0; busy=0, done=0 throughout.
2. Accumulate: start at (0,0), mode 0, blk all 32'h3F800000 at edge t -> done exactly at t+5; addrs 0,1,4,5 = 32'h3F800000, others 0. Repeat with blk all 32'h40000000 -> same addrs = 32'h40400000.
3. Overwrite: start at (1,1), mode 1, blk all 32'h3F000000 over the state from test 2 -> addrs 5,6,9,10 = 32'h3F000000; addrs 0,1,4 still 32'h40400000.
4. Clipping: start at (3,3), blk all 32'h3F800000 on a cleared matrix -> only addr 15 = 32'h3F800000; done at t+5; with BLK_ACC_CLIP_ERR_EN, clip_err=1 until next start.
5. Handshake: pulse start again at t+2 with different blk -> ignored, result unchanged. Assert clear and start together in IDLE -> all words 0, done 1 cycle later, no merge.
6. Reset mid-RUN: drop rst_n at t+2 -> busy=0 immediately; all words 0 after release; a fresh start completes normally.
7. Rerun tests 2 and 4 with LANES=4 -> done at t+2, identical memory contents.

Source files
------------

// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared defaults, FSM encoding and FP32 add for the block accumulator
//
// Purpose : common types/constants for block_accumulator and block_acc_lane.
// Contents: default geometry (DEF_*), state enum, FP constants, addr_w(),
//           fp_add() combinational IEEE-754 single adder
//           (denormals flushed to zero, round-to-nearest-even).
package block_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_J      = 2;
   localparam int DEF_K      = 2;
   localparam int DEF_A_M    = 4;
   localparam int DEF_B_N    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

   // Address width for a memory of n words; never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b;
      logic [26:0] ma, mb, mbs;
      logic [27:0] s;
      logic [24:0] m;
      int          ea, d;
      // Inf/NaN propagate unchanged; zero/denormal operands act as zero.
      if (x[30:23] == 8'hFF) return x;
      if (y[30:23] == 8'hFF) return y;
      if (y[30:23] == 8'h00) return (x[30:23] == 8'h00) ? FP_ZERO : x;
      if (x[30:23] == 8'h00) return y;
      // a carries the larger magnitude, so the result sign is a's sign.
      if (x[30:0] >= y[30:0]) begin
         a = x;
         b = y;
      end else begin
         a = y;
         b = x;
      end
      ea = int'(a[30:23]);
      d  = ea - int'(b[30:23]);
      // hidden bit + 23 fraction bits + guard/round/sticky
      ma = {1'b1, a[22:0], 3'b000};
      mb = {1'b1, b[22:0], 3'b000};
      if (d > 26) begin
         mbs = 27'd1;
      end else begin
         mbs = mb >> d;
         if ((mb & ~({27{1'b1}} << d)) != 27'd0) mbs[0] = 1'b1;
      end
      if (a[31] == b[31]) begin
         s = {1'b0, ma} + {1'b0, mbs};
         if (s[27]) begin
            s  = {1'b0, s[27:2], s[1] | s[0]};
            ea = ea + 1;
         end
      end else begin
         s = {1'b0, ma} - {1'b0, mbs};
         if (s == 28'd0) return FP_ZERO;
         for (int k = 0; k < 26; k++) begin
            if (!s[26]) begin
               s  = s << 1;
               ea = ea - 1;
            end
         end
      end
      m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
      if (m[24]) begin
         m  = m >> 1;
         ea = ea + 1;
      end
      if (ea >= 255) return {a[31], 8'hFF, 23'd0};
      if (ea <= 0)   return {a[31], 31'd0};
      return {a[31], ea[7:0], m[22:0]};
   endfunction

endpackage

// File: rtl/block_acc_lane.sv
// rtl/block_acc_lane.sv - one merge lane: element index to matrix address, bounds check, add/overwrite
//
// Ports:
//   idx        element index within the block (row-major i*K+j)
//   mode       0 = accumulate, 1 = overwrite
//   start_row  block origin row
//   start_col  block origin column
//   blk_elem   block element at idx
//   old_data   current matrix word at waddr
//   we         write this lane's result
//   clipped    element exists but falls outside the matrix
//   waddr      row-major matrix address
//   wdata      merged word
module block_acc_lane
   import block_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int J      = DEF_J,
   parameter int K      = DEF_K,
   parameter int A_M    = DEF_A_M,
   parameter int B_N    = DEF_B_N,
   parameter int CW     = 4,
   parameter int AW     = 4
) (
   input  logic [CW-1:0]     idx,
   input  logic              mode,
   input  logic [9:0]        start_row,
   input  logic [9:0]        start_col,
   input  logic [DATA_W-1:0] blk_elem,
   input  logic [DATA_W-1:0] old_data,
   output logic              we,
   output logic              clipped,
   output logic [AW-1:0]     waddr,
   output logic [DATA_W-1:0] wdata
);

   localparam int NE = J * K;

   logic        active;
   logic        in_range;
   logic [10:0] r;
   logic [10:0] c;

   always_comb begin
      active   = (32'(idx) < NE);
      // 11-bit sums: an origin near 1023 cannot wrap back into the matrix.
      r        = {1'b0, start_row} + 11'(32'(idx) / K);
      c        = {1'b0, start_col} + 11'(32'(idx) % K);
      in_range = (32'(r) < A_M) && (32'(c) < B_N);
      we       = active && in_range;
      clipped  = active && !in_range;
      waddr    = AW'(32'(r) * B_N + 32'(c));
      wdata    = mode ? blk_elem : DATA_W'(fp_add(32'(old_data), 32'(blk_elem)));
   end

endmodule

// File: rtl/block_accumulator.sv
// rtl/block_accumulator.sv - result matrix that merges J x K blocks by accumulate or overwrite
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, mode       merge request (accepted when idle), 0 = accumulate, 1 = overwrite
//   start_row/col     block origin, sampled with start
//   blk_in            flattened block, element i*K+j at [(i*K+j)*DATA_W +: DATA_W]
//   clear             zero whole matrix (accepted when idle, wins over start)
//   busy, done        busy in RUN/CLEAR/DONE, done pulses one cycle on completion
//   rd_addr, rd_data  row-major read port, registered, 1-cycle latency
//   clip_err          only with BLK_ACC_CLIP_ERR_EN: last merge clipped an element
module block_accumulator
   import block_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int J      = DEF_J,
   parameter int K      = DEF_K,
   parameter int A_M    = DEF_A_M,
   parameter int B_N    = DEF_B_N,
   parameter int LANES  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          mode,
   input  logic [9:0]                    start_row,
   input  logic [9:0]                    start_col,
   input  logic [J*K*DATA_W-1:0]         blk_in,
   input  logic                          clear,
   output logic                          busy,
   output logic                          done,
`ifdef BLK_ACC_CLIP_ERR_EN
   output logic                          clip_err,
`endif
   input  logic [addr_w(A_M*B_N)-1:0]    rd_addr,
   output logic [DATA_W-1:0]             rd_data
);

   localparam int DEPTH = A_M * B_N;
   localparam int AW    = addr_w(DEPTH);
   localparam int NE    = J * K;
   localparam int CW    = addr_w(NE + LANES) + 1;

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_CLEAR = ST_CLEAR;
   localparam logic [1:0] S_DONE  = ST_DONE;

   logic [1:0]            state;
   logic [CW-1:0]         e;
   logic                  mode_q;
   logic [9:0]            row_q;
   logic [9:0]            col_q;
   logic [NE*DATA_W-1:0]  blk_q;
   logic [DATA_W-1:0]     mem [DEPTH];

   logic [LANES-1:0]      lane_we;
   logic [LANES-1:0]      lane_clip;
   logic [CW-1:0]         lane_idx   [LANES];
   logic [AW-1:0]         lane_addr  [LANES];
   logic [DATA_W-1:0]     lane_wdata [LANES];
   logic [DATA_W-1:0]     lane_old   [LANES];
   logic [DATA_W-1:0]     lane_elem  [LANES];

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l]  = e + CW'(l);
      // Lanes past the end of the block select garbage here; the lane masks them.
      assign lane_elem[l] = blk_q[lane_idx[l]*DATA_W +: DATA_W];
      assign lane_old[l]  = mem[lane_addr[l]];

      block_acc_lane #(
         .DATA_W (DATA_W),
         .J      (J),
         .K      (K),
         .A_M    (A_M),
         .B_N    (B_N),
         .CW     (CW),
         .AW     (AW)
      ) u_lane (
         .idx       (lane_idx[l]),
         .mode      (mode_q),
         .start_row (row_q),
         .start_col (col_q),
         .blk_elem  (lane_elem[l]),
         .old_data  (lane_old[l]),
         .we        (lane_we[l]),
         .clipped   (lane_clip[l]),
         .waddr     (lane_addr[l]),
         .wdata     (lane_wdata[l])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         e       <= '0;
         mode_q  <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         blk_q   <= '0;
         rd_data <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // Reads see the array before this edge's writes land.
         rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  state <= S_CLEAR;
               end else if (start) begin
                  mode_q <= mode;
                  row_q  <= start_row;
                  col_q  <= start_col;
                  blk_q  <= blk_in;
                  e      <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  if (lane_we[l]) mem[lane_addr[l]] <= lane_wdata[l];
               end
               e <= e + CW'(LANES);
               if (32'(e) + LANES >= NE) state <= S_DONE;
            end
            S_CLEAR: begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BLK_ACC_CLIP_ERR_EN
   logic clip_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_acc <= 1'b0;
         clip_err <= 1'b0;
      end else if (state == S_IDLE && (clear || start)) begin
         clip_acc <= 1'b0;
         clip_err <= 1'b0;
      end else if (state == S_RUN) begin
         clip_acc <= clip_acc | (|lane_clip);
         // Raised as the FSM enters DONE so it is visible with the done pulse.
         if (32'(e) + LANES >= NE) clip_err <= clip_acc | (|lane_clip);
      end
   end
`else
   logic unused_clip;
   assign unused_clip = |lane_clip;
`endif

endmodule
